// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
// Default geometry of the pipelined register file and the types that go
// with it. The modules take these as parameter defaults, so an instance
// can still be built with a different width or register count.
// ---------------------------------------------------------------------------
package register_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_SEL_W    = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_SEL_W-1:0]  reg_idx_t;  // register index
    typedef logic [DEF_DATA_W-1:0] word_t;     // register contents

endpackage : register_file_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Keeps one busy bit per register. A bit is set when a destination register
// is reserved and cleared when the write to that register arrives. Register
// 0 is never busy.
//
// Ports
//   clk, rst  : clock and asynchronous active-high reset
//   wen, wsel : write strobe and index; a write clears the target's busy bit
//   resv_en   : request to reserve resv_sel
//   resv_sel  : register to reserve
//   flush     : clears every busy bit and cancels a same-cycle reservation
//   rsel      : read-port indices, used to look up rbusy
//   resv_ok   : reservation of resv_sel is acceptable this cycle
//   rbusy     : per read port, the register read awaits a write
//   busy_cnt  : registered count of busy registers
// ---------------------------------------------------------------------------
module rf_scoreboard
    import register_file_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int BYPASS   = 1,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen,
    input  logic [SEL_W-1:0]             wsel,
    input  logic                         resv_en,
    input  logic [SEL_W-1:0]             resv_sel,
    input  logic                         flush,
    input  logic [NUM_RD-1:0][SEL_W-1:0] rsel,
    output logic                         resv_ok,
    output logic [NUM_RD-1:0]            rbusy,
    output logic [SEL_W:0]               busy_cnt
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [SEL_W:0]      busy_cnt_q, busy_cnt_d;
    logic                wr_hit;
    logic                resv_fwd;

    // Writes to register 0 are discarded, so they never count as a write.
    assign wr_hit = wen && (wsel != '0);

    // A write landing on the reserved register in the same cycle frees it
    // early when forwarding is enabled.
    assign resv_fwd = (BYPASS != 0) && wr_hit && (wsel == resv_sel);
    assign resv_ok  = (resv_sel == '0) || !busy_q[resv_sel] || resv_fwd;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[wsel] = 1'b0;
        end
        // Applied after the write clear, so a reservation wins on a collision.
        if (resv_en && resv_ok && (resv_sel != '0)) begin
            busy_d[resv_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;

        // Count the next state so busy_cnt tracks busy_q cycle for cycle.
        // Register 0 is never busy, so the count tops out at NUM_REGS-1.
        busy_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_cnt_d += {{SEL_W{1'b0}}, busy_d[r]};
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rbusy[i] = busy_q[rsel[i]];
            // Forwarded data satisfies the read, so it is not waiting.
            if ((BYPASS != 0) && wr_hit && (wsel == rsel[i])) begin
                rbusy[i] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule : rf_scoreboard

// File: rtl/pipe_register_file.sv
// ---------------------------------------------------------------------------
// pipe_register_file
// Register file for a pipelined core: one write port, NUM_RD combinational
// read ports with optional same-cycle write forwarding, and a scoreboard of
// reserved destination registers. Register 0 is hard-wired to zero.
//
// Ports
//   clk, rst           : clock and asynchronous active-high reset
//   wen, wsel, wdat    : write port, takes effect on the rising edge
//   rsel / rdat        : per-port read index and combinational read data
//   rbusy              : per-port flag, read register awaits a pending write
//   resv_en, resv_sel  : reserve a destination register
//   resv_ok            : the reservation is acceptable this cycle
//   flush              : clear all reservations (register data untouched)
//   busy_cnt           : number of reserved registers
// ---------------------------------------------------------------------------
module pipe_register_file
    import register_file_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int BYPASS   = 1,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [SEL_W-1:0]              wsel,
    input  logic [DATA_W-1:0]             wdat,
    input  logic [NUM_RD-1:0][SEL_W-1:0]  rsel,
    output logic [NUM_RD-1:0][DATA_W-1:0] rdat,
    output logic [NUM_RD-1:0]             rbusy,
    input  logic                          resv_en,
    input  logic [SEL_W-1:0]              resv_sel,
    output logic                          resv_ok,
    input  logic                          flush,
    output logic [SEL_W:0]                busy_cnt
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_hit;

    assign wr_hit = wen && (wsel != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wsel] = wdat;
        end
    end

    // NOTE: the storage array is reset on purpose: every register must read
    // zero straight after reset. This rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdat[i] = (rsel[i] == '0) ? '0 : regs_q[rsel[i]];
            // Forward the in-flight write so a consumer issued in the same
            // cycle does not see the stale value.
            if ((BYPASS != 0) && wr_hit && (wsel == rsel[i])) begin
                rdat[i] = wdat;
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .wsel     (wsel),
        .resv_en  (resv_en),
        .resv_sel (resv_sel),
        .flush    (flush),
        .rsel     (rsel),
        .resv_ok  (resv_ok),
        .rbusy    (rbusy),
        .busy_cnt (busy_cnt)
    );

endmodule : pipe_register_file

// File: tb/tb_pipe_register_file.sv
// ---------------------------------------------------------------------------
// tb_pipe_register_file
// Directed bench for pipe_register_file. Two instances share all inputs:
// dut_a forwards writes (BYPASS=1), dut_b does not (BYPASS=0).
// ---------------------------------------------------------------------------
module tb_pipe_register_file;
    import register_file_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wen;
    reg_idx_t             wsel;
    word_t                wdat;
    logic [1:0][4:0]      rsel;
    logic                 resv_en;
    reg_idx_t             resv_sel;
    logic                 flush;

    logic [1:0][31:0]     rdat_a, rdat_b;
    logic [1:0]           rbusy_a, rbusy_b;
    logic                 resv_ok_a, resv_ok_b;
    logic [5:0]           busy_cnt_a, busy_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_register_file #(.BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat_a), .rbusy(rbusy_a),
        .resv_en(resv_en), .resv_sel(resv_sel), .resv_ok(resv_ok_a),
        .flush(flush), .busy_cnt(busy_cnt_a)
    );

    pipe_register_file #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat_b), .rbusy(rbusy_b),
        .resv_en(resv_en), .resv_sel(resv_sel), .resv_ok(resv_ok_b),
        .flush(flush), .busy_cnt(busy_cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; resv_en = 1'b0; flush = 1'b0;
    endtask

    task automatic reserve(input int idx);
        idle();
        resv_en = 1'b1; resv_sel = reg_idx_t'(idx);
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; wsel = '0; wdat = '0; rsel = '0;
        resv_en = 1'b0; resv_sel = '0; flush = 1'b0;
        #1;
        check("reset_busy_cnt", busy_cnt_a, 0);
        check("reset_rdat0",    rdat_a[0], 0);
        check("reset_rbusy",    rbusy_a, 0);
        check("reset_resv_ok",  resv_ok_a, 1);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Write r5, forwarded on dut_a only, then visible on both.
        wen = 1'b1; wsel = 5; wdat = 32'hDEADBEEF; rsel[0] = 5;
        #1;
        check("bypass_r5_a", rdat_a[0], 32'hDEADBEEF);
        check("nobypass_r5_b", rdat_b[0], 0);
        tick(); idle(); #1;
        check("read_r5_a", rdat_a[0], 32'hDEADBEEF);
        check("read_r5_b", rdat_b[0], 32'hDEADBEEF);

        // Writes to r0 are discarded and never forwarded.
        wen = 1'b1; wsel = 0; wdat = 32'hFFFF_FFFF; rsel[0] = 0;
        #1;
        check("r0_no_bypass", rdat_a[0], 0);
        tick(); idle(); #1;
        check("r0_reads_zero", rdat_a[0], 0);

        // Reserve r7, then write it while port 1 reads it.
        reserve(7);
        rsel[1] = 7; #1;
        check("r7_cnt_a", busy_cnt_a, 1);
        check("r7_rbusy_a", rbusy_a[1], 1);
        wen = 1'b1; wsel = 7; wdat = 32'h1234; #1;
        check("r7_bypass_a", rdat_a[1], 32'h1234);
        check("r7_bypass_rbusy_a", rbusy_a[1], 0);
        check("r7_old_b", rdat_b[1], 0);
        check("r7_rbusy_b", rbusy_b[1], 1);
        tick(); idle(); #1;
        check("r7_cnt_after_wr_a", busy_cnt_a, 0);
        check("r7_cnt_after_wr_b", busy_cnt_b, 0);
        check("r7_data_b", rdat_b[1], 32'h1234);

        // Double reservation of r3 is rejected, the write frees it.
        reserve(3);
        rsel[0] = 3; #1;
        check("r3_cnt", busy_cnt_a, 1);
        check("r3_rbusy", rbusy_a[0], 1);
        resv_en = 1'b1; resv_sel = 3; #1;
        check("r3_second_resv_ok", resv_ok_a, 0);
        tick(); idle(); #1;
        check("r3_cnt_unchanged", busy_cnt_a, 1);
        wen = 1'b1; wsel = 3; wdat = 32'h33;
        tick(); idle(); #1;
        check("r3_cnt_after_wr", busy_cnt_a, 0);
        check("r3_rbusy_after_wr", rbusy_a[0], 0);
        check("r3_data", rdat_a[0], 32'h33);

        // Write and reservation collide on busy r9.
        reserve(9);
        wen = 1'b1; wsel = 9; wdat = 32'h99;
        resv_en = 1'b1; resv_sel = 9; rsel[0] = 9; #1;
        check("r9_resv_ok_a", resv_ok_a, 1);
        check("r9_resv_ok_b", resv_ok_b, 0);
        tick(); idle(); #1;
        check("r9_cnt_a", busy_cnt_a, 1);
        check("r9_rbusy_a", rbusy_a[0], 1);
        check("r9_data_a", rdat_a[0], 32'h99);
        check("r9_cnt_b", busy_cnt_b, 0);

        // Reserving r0 is always accepted and never counts.
        resv_en = 1'b1; resv_sel = 0; #1;
        check("r0_resv_ok", resv_ok_a, 1);
        tick(); idle(); #1;
        check("r0_resv_cnt", busy_cnt_a, 1);

        // Flush beats a same-cycle reservation.
        reserve(1); reserve(2); reserve(4);
        #1;
        check("pre_flush_cnt", busy_cnt_a, 4);
        flush = 1'b1; resv_en = 1'b1; resv_sel = 6; rsel[0] = 6;
        tick(); idle(); #1;
        check("flush_cnt", busy_cnt_a, 0);
        check("flush_r6_rbusy", rbusy_a[0], 0);
        check("flush_keeps_data", rdat_a[1], 32'h1234);

        // Asynchronous reset mid-operation.
        reserve(1); reserve(2); reserve(3);
        wen = 1'b1; wsel = 5; wdat = 32'hA5;
        tick(); idle();
        rsel[0] = 5; rsel[1] = 1; resv_sel = 1; #1;
        check("pre_rst_cnt", busy_cnt_a, 3);
        check("pre_rst_r5", rdat_a[0], 32'hA5);
        check("pre_rst_rbusy", rbusy_a, 2'b10);
        check("pre_rst_resv_ok", resv_ok_a, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_cnt", busy_cnt_a, 0);
        check("rst_rbusy", rbusy_a, 0);
        check("rst_r5", rdat_a[0], 0);
        check("rst_resv_ok", resv_ok_a, 1);
        check("rst_cnt_b", busy_cnt_b, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_r5", rdat_a[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule : tb_pipe_register_file
